// File: rtl/irq_pkg.sv
// Shared constants for the interrupt controller: register map, STATUS layout,
// vector defaults and the widths of the priority index and nesting depth.
package irq_pkg;

  localparam int IDX_W   = 4;
  localparam int DEPTH_W = 2;

  localparam logic [15:0] VEC_BASE_DEF   = 16'h0020;
  localparam int          VEC_STRIDE_DEF = 4;
  localparam int          MAX_DEPTH_DEF  = 3;

  typedef enum logic [2:0] {
    REG_MASK   = 3'd0,
    REG_PEND   = 3'd1,
    REG_ISR    = 3'd2,
    REG_MODE   = 3'd3,
    REG_STATUS = 3'd4
  } reg_addr_e;

  localparam int STATUS_ERR_BIT   = 15;
  localparam int STATUS_DEPTH_LSB = 4;
  localparam int STATUS_TOP_LSB   = 0;

endpackage

// File: rtl/irq_prio_enc.sv
// Find-first-set: index of the lowest set request bit (highest priority)
// plus a flag saying whether any bit was set.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Prioritised, nesting-aware interrupt controller: synchronises and latches
// requests, arbitrates against the in-service stack and exposes a register file.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int          N_SRC      = 8,
  parameter logic [15:0] VEC_BASE   = VEC_BASE_DEF,
  parameter int          VEC_STRIDE = VEC_STRIDE_DEF,
  parameter int          MAX_DEPTH  = MAX_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             int_en,
  input  logic             insn_ce,
  input  logic             iret_detected,
  output logic             irq_take,
  output logic [15:0]      irq_vector,
  input  logic             io_sel,
  input  logic [2:0]       io_ad,
  input  logic             io_sw,
  input  logic             io_lw,
  input  logic [15:0]      io_wdata,
  output logic [15:0]      io_rdata
);

  logic [N_SRC-1:0]   irq_s1, irq_s, irq_s_d;
  logic [N_SRC-1:0]   pend_q, mask_q, mode_q;
  logic [IDX_W-1:0]   stack_q [MAX_DEPTH];
  logic [DEPTH_W-1:0] depth_q;
  logic               err_q, take_q;

  logic [N_SRC-1:0]   pend_view, isr, prio_ok, eligible, take_oh, w1c, edge_set;
  logic [IDX_W-1:0]   elig_idx, top_idx;
  logic               elig_valid, top_valid;
  logic               wr_en, iret_pop, wdata_unused;

  assign wdata_unused = ^io_wdata;

  // Level sources expose the synchronised line directly; edge sources the latch.
  assign pend_view = (pend_q & mode_q) | (irq_s & ~mode_q);
  assign edge_set  = irq_s & ~irq_s_d & mode_q;

  always_comb begin
    isr = '0;
    for (int k = 0; k < MAX_DEPTH; k++) begin
      if (DEPTH_W'(k) < depth_q) isr = isr | (N_SRC'(1) << stack_q[k]);
    end
  end

  // Nested entries are strictly higher priority, so the lowest ISR bit is the top.
  irq_prio_enc #(.N(N_SRC)) u_top_enc (.req(isr), .idx(top_idx), .valid(top_valid));

  always_comb begin
    prio_ok = '0;
    for (int i = 0; i < N_SRC; i++) begin
      prio_ok[i] = !top_valid || (IDX_W'(i) < top_idx);
    end
  end

  assign eligible = pend_view & mask_q & prio_ok;

  irq_prio_enc #(.N(N_SRC)) u_elig_enc (.req(eligible), .idx(elig_idx), .valid(elig_valid));

  assign irq_take   = int_en & insn_ce & elig_valid &
                      (depth_q < DEPTH_W'(MAX_DEPTH)) & ~take_q;
  assign irq_vector = elig_valid ? (VEC_BASE + 16'(elig_idx) * 16'(VEC_STRIDE)) : VEC_BASE;

  assign take_oh  = irq_take ? (N_SRC'(1) << elig_idx) : '0;
  assign wr_en    = io_sel & io_sw;
  assign w1c      = (wr_en && io_ad == REG_PEND) ? io_wdata[N_SRC-1:0] : '0;
  assign iret_pop = iret_detected && (depth_q != '0);

  // A take alongside an iret replaces the top entry, mirroring the CPU depth counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_s1  <= '0;
      irq_s   <= '0;
      irq_s_d <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      mode_q  <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
      take_q  <= 1'b0;
      for (int k = 0; k < MAX_DEPTH; k++) stack_q[k] <= '0;
    end else begin
      irq_s1  <= irq_in;
      irq_s   <= irq_s1;
      irq_s_d <= irq_s;
      pend_q  <= (pend_q & ~(w1c | take_oh)) | edge_set;
      take_q  <= irq_take;

      if (wr_en && io_ad == REG_MASK) mask_q <= io_wdata[N_SRC-1:0];
      if (wr_en && io_ad == REG_MODE) mode_q <= io_wdata[N_SRC-1:0];

      if (irq_take && iret_pop) begin
        stack_q[depth_q - 2'd1] <= elig_idx;
      end else if (irq_take) begin
        stack_q[depth_q] <= elig_idx;
        depth_q          <= depth_q + 2'd1;
      end else if (iret_pop) begin
        depth_q <= depth_q - 2'd1;
      end

      if (wr_en && io_ad == REG_STATUS && io_wdata[STATUS_ERR_BIT]) err_q <= 1'b0;
      if (iret_detected && depth_q == '0) err_q <= 1'b1;
    end
  end

  always_comb begin
    io_rdata = '0;
    if (io_sel && io_lw) begin
      case (io_ad)
        REG_MASK: io_rdata = 16'(mask_q);
        REG_PEND: io_rdata = 16'(pend_view);
        REG_ISR:  io_rdata = 16'(isr);
        REG_MODE: io_rdata = 16'(mode_q);
        REG_STATUS: begin
          io_rdata[STATUS_ERR_BIT]                  = err_q;
          io_rdata[STATUS_DEPTH_LSB +: DEPTH_W]     = depth_q;
          io_rdata[STATUS_TOP_LSB +: IDX_W]         = top_idx;
        end
        default: io_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl: takes, nesting, gating, depth
// limit, iret error, level sources, back-to-back blocking and reset mid-ISR.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq_in;
  logic        int_en, insn_ce, iret_detected;
  logic        irq_take;
  logic [15:0] irq_vector;
  logic        io_sel, io_sw, io_lw;
  logic [2:0]  io_ad;
  logic [15:0] io_wdata, io_rdata;

  int          checks = 0;
  int          errors = 0;
  int          take_count = 0;
  logic [15:0] last_vec = 16'h0;

  irq_ctrl #(.N_SRC(8), .VEC_BASE(16'h0020), .VEC_STRIDE(4), .MAX_DEPTH(3)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .int_en(int_en), .insn_ce(insn_ce),
    .iret_detected(iret_detected), .irq_take(irq_take), .irq_vector(irq_vector),
    .io_sel(io_sel), .io_ad(io_ad), .io_sw(io_sw), .io_lw(io_lw),
    .io_wdata(io_wdata), .io_rdata(io_rdata)
  );

  always #5 clk = ~clk;

  // Every take pulse is counted once, sampled mid-cycle.
  always @(negedge clk) begin
    if (irq_take === 1'b1) begin
      take_count++;
      last_vec = irq_vector;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    irq_in = '0; int_en = 1'b0; insn_ce = 1'b1; iret_detected = 1'b0;
    io_sel = 1'b0; io_sw = 1'b0; io_lw = 1'b0; io_ad = '0; io_wdata = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic io_write(input logic [2:0] a, input logic [15:0] d);
    io_sel = 1'b1; io_sw = 1'b1; io_ad = a; io_wdata = d;
    step();
    io_sel = 1'b0; io_sw = 1'b0; io_wdata = '0;
  endtask

  task automatic io_read(input logic [2:0] a, output logic [15:0] d);
    @(negedge clk);
    io_sel = 1'b1; io_lw = 1'b1; io_ad = a;
    #1;
    d = io_rdata;
    io_sel = 1'b0; io_lw = 1'b0;
  endtask

  task automatic pulse_src(input logic [7:0] m);
    step();
    irq_in = m;
    step();
    step();
    irq_in = '0;
  endtask

  task automatic do_iret();
    step();
    iret_detected = 1'b1;
    step();
    iret_detected = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] d;
    irq_in = '0; int_en = 1'b0; insn_ce = 1'b1; iret_detected = 1'b0;
    io_sel = 1'b0; io_sw = 1'b0; io_lw = 1'b0; io_ad = '0; io_wdata = '0;
    rst = 1'b1;
    step();
    step();
    checks++;
    if (irq_take !== 1'b0) begin errors++; $display("[TB] FAIL reset_take: got %b expected 0", irq_take); end
    checks++;
    if (irq_vector !== 16'h0020) begin errors++; $display("[TB] FAIL reset_vector: got %h expected 0020", irq_vector); end
    checks++;
    if (io_rdata !== 16'h0000) begin errors++; $display("[TB] FAIL reset_rdata: got %h expected 0000", io_rdata); end
    rst = 1'b0;
    io_read(3'd4, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("[TB] FAIL reset_status: got %h expected 0000", d); end
    io_write(3'd0, 16'hFFFF);
    io_read(3'd0, d);
    checks++;
    if (d !== 16'h00FF) begin errors++; $display("[TB] FAIL mask_width: got %h expected 00ff", d); end
    io_write(3'd5, 16'h1234);
    io_read(3'd5, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("[TB] FAIL unmapped_read: got %h expected 0000", d); end
  endtask

  task automatic test_edge_take();
    logic [15:0] d;
    int base;
    do_reset();
    io_write(3'd0, 16'h0005);
    io_write(3'd3, 16'h00FF);
    pulse_src(8'h04);
    wait_cycles(4);
    io_read(3'd1, d);
    checks++;
    if (d !== 16'h0004) begin errors++; $display("[TB] FAIL edge_pend: got %h expected 0004", d); end
    base = take_count;
    step();
    int_en = 1'b1;
    #1;
    checks++;
    if (irq_take !== 1'b1 || irq_vector !== 16'h0028) begin
      errors++; $display("[TB] FAIL edge_take: got take=%b vec=%h expected take=1 vec=0028", irq_take, irq_vector);
    end
    wait_cycles(5);
    checks++;
    if (take_count - base !== 1) begin errors++; $display("[TB] FAIL edge_take_once: got %0d takes expected 1", take_count - base); end
    io_read(3'd1, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("[TB] FAIL edge_pend_clear: got %h expected 0000", d); end
    io_read(3'd4, d);
    checks++;
    if (d !== 16'h0012) begin errors++; $display("[TB] FAIL edge_status: got %h expected 0012", d); end
    io_read(3'd2, d);
    checks++;
    if (d !== 16'h0004) begin errors++; $display("[TB] FAIL edge_isr: got %h expected 0004", d); end
    int_en = 1'b0;
  endtask

  task automatic test_nesting();
    logic [15:0] d;
    int base;
    do_reset();
    io_write(3'd0, 16'h00FF);
    io_write(3'd3, 16'h00FF);
    int_en = 1'b1;
    base = take_count;
    pulse_src(8'h08);
    wait_cycles(6);
    checks++;
    if (take_count - base !== 1 || last_vec !== 16'h002C) begin
      errors++; $display("[TB] FAIL nest_src3: got %0d takes vec=%h expected 1 vec=002c", take_count - base, last_vec);
    end
    pulse_src(8'h02);
    wait_cycles(6);
    checks++;
    if (take_count - base !== 2 || last_vec !== 16'h0024) begin
      errors++; $display("[TB] FAIL nest_src1: got %0d takes vec=%h expected 2 vec=0024", take_count - base, last_vec);
    end
    io_read(3'd4, d);
    checks++;
    if (d !== 16'h0021) begin errors++; $display("[TB] FAIL nest_status2: got %h expected 0021", d); end
    pulse_src(8'h20);
    wait_cycles(6);
    checks++;
    if (take_count - base !== 2) begin errors++; $display("[TB] FAIL nest_src5_blocked: got %0d takes expected 2", take_count - base); end
    io_read(3'd1, d);
    checks++;
    if (d !== 16'h0020) begin errors++; $display("[TB] FAIL nest_pend5: got %h expected 0020", d); end
    do_iret();
    wait_cycles(4);
    checks++;
    if (take_count - base !== 2) begin errors++; $display("[TB] FAIL nest_one_iret: got %0d takes expected 2", take_count - base); end
    io_read(3'd4, d);
    checks++;
    if (d !== 16'h0013) begin errors++; $display("[TB] FAIL nest_status1: got %h expected 0013", d); end
    do_iret();
    wait_cycles(4);
    checks++;
    if (take_count - base !== 3 || last_vec !== 16'h0034) begin
      errors++; $display("[TB] FAIL nest_src5_take: got %0d takes vec=%h expected 3 vec=0034", take_count - base, last_vec);
    end
    io_read(3'd4, d);
    checks++;
    if (d !== 16'h0015) begin errors++; $display("[TB] FAIL nest_status_src5: got %h expected 0015", d); end
    int_en = 1'b0;
  endtask

  task automatic test_gating();
    logic [15:0] d;
    int base;
    do_reset();
    io_write(3'd0, 16'h0001);
    io_write(3'd3, 16'h0001);
    base = take_count;
    pulse_src(8'h01);
    wait_cycles(5);
    checks++;
    if (take_count - base !== 0 || irq_take !== 1'b0) begin
      errors++; $display("[TB] FAIL gate_int_en: got %0d takes take=%b expected 0 takes", take_count - base, irq_take);
    end
    io_read(3'd1, d);
    checks++;
    if (d !== 16'h0001) begin errors++; $display("[TB] FAIL gate_pend: got %h expected 0001", d); end
    step();
    int_en = 1'b1;
    insn_ce = 1'b0;
    wait_cycles(3);
    checks++;
    if (take_count - base !== 0 || irq_take !== 1'b0) begin
      errors++; $display("[TB] FAIL gate_insn_ce: got %0d takes take=%b expected 0 takes", take_count - base, irq_take);
    end
    insn_ce = 1'b1;
    #1;
    checks++;
    if (irq_take !== 1'b1 || irq_vector !== 16'h0020) begin
      errors++; $display("[TB] FAIL gate_open: got take=%b vec=%h expected take=1 vec=0020", irq_take, irq_vector);
    end
    step();
    checks++;
    if (take_count - base !== 1) begin errors++; $display("[TB] FAIL gate_count: got %0d takes expected 1", take_count - base); end
    int_en = 1'b0;
  endtask

  task automatic test_depth_limit();
    logic [15:0] d;
    int base;
    do_reset();
    io_write(3'd0, 16'h00FF);
    io_write(3'd3, 16'h00FF);
    int_en = 1'b1;
    base = take_count;
    pulse_src(8'h40);
    wait_cycles(6);
    pulse_src(8'h10);
    wait_cycles(6);
    pulse_src(8'h04);
    wait_cycles(6);
    io_read(3'd4, d);
    checks++;
    if (d !== 16'h0032 || take_count - base !== 3) begin
      errors++; $display("[TB] FAIL depth3_status: got %h after %0d takes expected 0032 after 3", d, take_count - base);
    end
    pulse_src(8'h01);
    wait_cycles(6);
    checks++;
    if (take_count - base !== 3) begin errors++; $display("[TB] FAIL depth_limit: got %0d takes expected 3", take_count - base); end
    step();
    iret_detected = 1'b1;
    #1;
    checks++;
    if (irq_take !== 1'b0) begin errors++; $display("[TB] FAIL depth_limit_iret: got take=%b expected 0", irq_take); end
    step();
    iret_detected = 1'b0;
    #1;
    checks++;
    if (irq_take !== 1'b1 || irq_vector !== 16'h0020) begin
      errors++; $display("[TB] FAIL depth_after_iret: got take=%b vec=%h expected take=1 vec=0020", irq_take, irq_vector);
    end
    step();
    int_en = 1'b0;
    io_read(3'd4, d);
    checks++;
    if (d !== 16'h0030) begin errors++; $display("[TB] FAIL depth_status_top0: got %h expected 0030", d); end
    do_iret();
    pulse_src(8'h02);
    wait_cycles(5);
    step();
    int_en = 1'b1;
    iret_detected = 1'b1;
    #1;
    checks++;
    if (irq_take !== 1'b1 || irq_vector !== 16'h0024) begin
      errors++; $display("[TB] FAIL swap_take: got take=%b vec=%h expected take=1 vec=0024", irq_take, irq_vector);
    end
    step();
    iret_detected = 1'b0;
    int_en = 1'b0;
    io_read(3'd4, d);
    checks++;
    if (d !== 16'h0021) begin errors++; $display("[TB] FAIL swap_status: got %h expected 0021", d); end
    io_read(3'd2, d);
    checks++;
    if (d !== 16'h0042) begin errors++; $display("[TB] FAIL swap_isr: got %h expected 0042", d); end
  endtask

  task automatic test_iret_err();
    logic [15:0] d;
    do_reset();
    do_iret();
    io_read(3'd4, d);
    checks++;
    if (d !== 16'h8000) begin errors++; $display("[TB] FAIL err_set: got %h expected 8000", d); end
    wait_cycles(3);
    io_read(3'd4, d);
    checks++;
    if (d !== 16'h8000) begin errors++; $display("[TB] FAIL err_sticky: got %h expected 8000", d); end
    io_write(3'd4, 16'h8000);
    io_read(3'd4, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("[TB] FAIL err_clear: got %h expected 0000", d); end
  endtask

  task automatic test_level();
    logic [15:0] d;
    int base;
    do_reset();
    io_write(3'd0, 16'h0010);
    io_write(3'd3, 16'h0000);
    int_en = 1'b1;
    base = take_count;
    irq_in = 8'h10;
    wait_cycles(6);
    checks++;
    if (take_count - base !== 1 || last_vec !== 16'h0030) begin
      errors++; $display("[TB] FAIL level_take: got %0d takes vec=%h expected 1 vec=0030", take_count - base, last_vec);
    end
    wait_cycles(6);
    checks++;
    if (take_count - base !== 1) begin errors++; $display("[TB] FAIL level_no_retake: got %0d takes expected 1", take_count - base); end
    io_read(3'd1, d);
    checks++;
    if (d !== 16'h0010) begin errors++; $display("[TB] FAIL level_pend: got %h expected 0010", d); end
    io_read(3'd4, d);
    checks++;
    if (d !== 16'h0014) begin errors++; $display("[TB] FAIL level_status: got %h expected 0014", d); end
    do_iret();
    wait_cycles(4);
    checks++;
    if (take_count - base !== 2 || last_vec !== 16'h0030) begin
      errors++; $display("[TB] FAIL level_retake: got %0d takes vec=%h expected 2 vec=0030", take_count - base, last_vec);
    end
    irq_in = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (irq_take !== 1'b0 || irq_vector !== 16'h0020 || io_rdata !== 16'h0000) begin
      errors++; $display("[TB] FAIL midisr_reset_out: got take=%b vec=%h rdata=%h expected 0 0020 0000", irq_take, irq_vector, io_rdata);
    end
    io_read(3'd4, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("[TB] FAIL midisr_status: got %h expected 0000", d); end
    io_read(3'd0, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("[TB] FAIL midisr_mask: got %h expected 0000", d); end
    io_read(3'd2, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("[TB] FAIL midisr_isr: got %h expected 0000", d); end
    do_iret();
    io_read(3'd4, d);
    checks++;
    if (d !== 16'h8000) begin errors++; $display("[TB] FAIL midisr_iret_err: got %h expected 8000", d); end
    int_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] d;
    do_reset();
    io_write(3'd0, 16'h0008);
    io_write(3'd3, 16'h00FF);
    pulse_src(8'h09);
    wait_cycles(5);
    io_read(3'd1, d);
    checks++;
    if (d !== 16'h0009) begin errors++; $display("[TB] FAIL b2b_pend: got %h expected 0009", d); end
    step();
    int_en = 1'b1;
    io_sel = 1'b1; io_sw = 1'b1; io_ad = 3'd0; io_wdata = 16'h0009;
    #1;
    checks++;
    if (irq_take !== 1'b1 || irq_vector !== 16'h002C) begin
      errors++; $display("[TB] FAIL b2b_first: got take=%b vec=%h expected take=1 vec=002c", irq_take, irq_vector);
    end
    step();
    io_sel = 1'b0; io_sw = 1'b0; io_wdata = '0;
    #1;
    checks++;
    if (irq_take !== 1'b0 || irq_vector !== 16'h0020) begin
      errors++; $display("[TB] FAIL b2b_blocked: got take=%b vec=%h expected take=0 vec=0020", irq_take, irq_vector);
    end
    step();
    checks++;
    if (irq_take !== 1'b1 || irq_vector !== 16'h0020) begin
      errors++; $display("[TB] FAIL b2b_second: got take=%b vec=%h expected take=1 vec=0020", irq_take, irq_vector);
    end
    step();
    int_en = 1'b0;
    io_read(3'd4, d);
    checks++;
    if (d !== 16'h0020) begin errors++; $display("[TB] FAIL b2b_status: got %h expected 0020", d); end
  endtask

  initial begin
    $display("[TB] irq_ctrl directed bench starting");
    test_reset();
    test_edge_take();
    test_nesting();
    test_gating();
    test_depth_limit();
    test_iret_err();
    test_level();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
